// File: rtl/ercm_mult_pipe.sv
// Pipelined approximate multiplier: OR-compression tree with masked error recovery.
// Define ERCM_ERR_STAT_EN to add the error flag/counter ports (err_clr, err_flag, err_cnt).
module ercm_mult_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LSB_CUT = 4
) (
`ifdef ERCM_ERR_STAT_EN
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [15:0]          err_cnt,
`endif
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  input  logic [2*WIDTH-1:0]   in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [1:0]           out_mode
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned Levels = $clog2(WIDTH);
  localparam logic [PW-1:0] CutMask = ~(PW'((64'd1 << LSB_CUT) - 64'd1));

  logic [PW-1:0] rows [WIDTH];
  logic [PW-1:0] sum_d, carry_d, exact_d;
  logic          en;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rows[i] = in_a[i] ? (PW'(in_b) << i) : '0;
    end
    carry_d = '0;
    // In-place pairwise reduction; row k is written only after rows 2k/2k+1 are consumed.
    for (int l = 0; l < Levels; l++) begin
      for (int k = 0; k < (WIDTH >> (l + 1)); k++) begin
        carry_d = carry_d | (rows[2*k] & rows[2*k+1]);
        rows[k] = rows[2*k] | rows[2*k+1];
      end
    end
    sum_d = rows[0];
`ifdef ERCM_ERR_STAT_EN
    exact_d = PW'(in_a) * PW'(in_b);
`else
    exact_d = in_mode[1] ? PW'(in_a) * PW'(in_b) : '0;
`endif
  end

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic          v1_q, v2_q, v3_q;
  logic [PW-1:0] sum1_q, carry1_q, exact1_q, mask1_q;
  logic [1:0]    mode1_q, mode2_q;
  logic [PW-1:0] sum2_q, rec2_q, exact2_q;
  logic [PW-1:0] prod3_q;
  logic [1:0]    mode3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum1_q   <= '0;
      carry1_q <= '0;
      exact1_q <= '0;
      mask1_q  <= '0;
      mode1_q  <= '0;
    end else if (en && in_valid) begin
      sum1_q   <= sum_d;
      carry1_q <= carry_d;
      exact1_q <= exact_d;
      mask1_q  <= in_mask;
      mode1_q  <= in_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum2_q   <= '0;
      rec2_q   <= '0;
      exact2_q <= '0;
      mode2_q  <= '0;
    end else if (en && v1_q) begin
      sum2_q   <= sum1_q;
      rec2_q   <= carry1_q & mask1_q & CutMask;
      exact2_q <= exact1_q;
      mode2_q  <= mode1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod3_q <= '0;
      mode3_q <= '0;
    end else if (en && v2_q) begin
      mode3_q <= mode2_q;
      if (mode2_q[1])      prod3_q <= exact2_q;
      else if (mode2_q[0]) prod3_q <= sum2_q + rec2_q;
      else                 prod3_q <= sum2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_prod  = prod3_q;
  assign out_mode  = mode3_q;

`ifdef ERCM_ERR_STAT_EN
  logic [PW-1:0] exact3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact3_q <= '0;
    end else if (en && v2_q) begin
      exact3_q <= exact2_q;
    end
  end

  assign err_flag = v3_q && !mode3_q[1] && (prod3_q != exact3_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_flag && out_ready && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ercm_mult_pipe.sv
// Directed self-checking bench for ercm_mult_pipe (WIDTH=8, LSB_CUT=4).
module tb_ercm_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  in_mode = '0;
  logic [15:0] in_mask = 16'hFFFF;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_prod;
  logic [1:0]  out_mode;
`ifdef ERCM_ERR_STAT_EN
  logic        err_clr = 1'b0;
  logic        err_flag;
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ercm_mult_pipe #(.WIDTH(8), .LSB_CUT(4)) dut (
`ifdef ERCM_ERR_STAT_EN
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_mode  (out_mode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Send one beat with out_ready high, check latency/result, then let it be consumed.
  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] mode, input logic [15:0] mask,
                         input logic [15:0] exp, input logic exp_err);
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; in_mode = mode; in_mask = mask;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " prod"}, out_prod, exp);
    check({tag, " mode"}, out_mode, mode);
`ifdef ERCM_ERR_STAT_EN
    check({tag, " err_flag"}, err_flag, exp_err);
`else
    if (exp_err) begin end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, cyc, outs_after_rst;
    logic acc, take, hold_pend;
    logic [15:0] held;
    logic [15:0] exp_q[$];
    logic [15:0] ea, eb;

    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_prod", out_prod, 0);
    check("reset out_mode", out_mode, 0);
    check("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("t1 ff*ff exact", 8'hFF, 8'hFF, 2'd2, 16'hFFFF, 16'hFE01, 1'b0);
    run_one("t2 m0", 8'h03, 8'h18, 2'd0, 16'hFFFF, 16'h0038, 1'b1);
    run_one("t2 m1", 8'h03, 8'h18, 2'd1, 16'hFFFF, 16'h0048, 1'b0);
    run_one("t2 m1 mask0", 8'h03, 8'h18, 2'd1, 16'h0000, 16'h0038, 1'b1);
    run_one("t3 m0", 8'h03, 8'h03, 2'd0, 16'hFFFF, 16'h0007, 1'b1);
    run_one("t3 m1", 8'h03, 8'h03, 2'd1, 16'hFFFF, 16'h0007, 1'b1);
    run_one("t3 m2", 8'h03, 8'h03, 2'd2, 16'hFFFF, 16'h0009, 1'b0);
    run_one("t3 m3", 8'h03, 8'h03, 2'd3, 16'hFFFF, 16'h0009, 1'b0);

    // Test 4: 8 back-to-back exact beats, out_ready low in cycles 4..6.
    sent = 0; got = 0; hold_pend = 1'b0; held = '0;
    for (cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = (sent < 8);
      in_a = 8'(sent * 17 + 3);
      in_b = 8'(sent * 29 + 5);
      in_mode = 2'd2;
      in_mask = 16'hFFFF;
      #1;
      if (hold_pend) check("t4 hold prod", out_prod, held);
      if (out_valid && !out_ready) check("t4 in_ready stall", in_ready, 0);
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      hold_pend = out_valid && !out_ready;
      held = out_prod;
      if (take) begin
        if (exp_q.size() == 0) check("t4 spurious output", 1, 0);
        else check("t4 stream prod", out_prod, exp_q.pop_front());
        got++;
      end
      if (acc) begin
        ea = 16'(in_a); eb = 16'(in_b);
        exp_q.push_back(ea * eb);
        sent++;
      end
      @(posedge clk);
    end
    check("t4 beats out", got, 8);
    @(negedge clk);
    in_valid = 1'b0;

    // Test 5: reset with 2 beats in flight.
    in_a = 8'h11; in_b = 8'h22; in_mode = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = 8'h33;
    @(posedge clk);
    #2 in_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("t5 rst out_valid", out_valid, 0);
    check("t5 rst out_prod", out_prod, 0);
    check("t5 rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    outs_after_rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (out_valid) outs_after_rst++;
    end
    check("t5 stale outputs", outs_after_rst, 0);

`ifdef ERCM_ERR_STAT_EN
    check("t6 cnt after reset", err_cnt, 0);
    for (int i = 0; i < 5; i++)
      run_one("t6 err beat", 8'h03, 8'h03, 2'd0, 16'hFFFF, 16'h0007, 1'b1);
    check("t6 err_cnt 5", err_cnt, 5);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t6 err_cnt clr", err_cnt, 0);
    // Fill the counter to saturation with a continuous erroring stream.
    @(negedge clk);
    in_a = 8'h03; in_b = 8'h03; in_mode = 2'd0; in_mask = 16'hFFFF;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6 err_cnt full", err_cnt, 16'hFFFF);
    run_one("t6 sat beat", 8'h03, 8'h03, 2'd0, 16'hFFFF, 16'h0007, 1'b1);
    check("t6 err_cnt sat", err_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
